cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Board-facing run/step controller sitting directly upstream of the clock divider.
- Conditions the raw reset button, step button and run/step slide switch.
- Drives the divider's active-high reset and a CPU clock-enable, so the CPU can free-run or advance one CPU period per step-button press.
- Runs on the 100 MHz board clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a debounced input changes (10 ms at 100 MHz).
- RST_HOLD_CYCLES, 16, minimum cycles O_DIV_RST is held high after any reset event.
- STEP_PULSE_CYCLES, 10, cycles O_CPU_EN stays high per step; equals one CPU period (divider cycle).

Ports:
- I_CLK  input  1  board clock, all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- btn_rst  input  1  raw reset pushbutton, asynchronous, bouncy, active-high.
- btn_step  input  1  raw step pushbutton, asynchronous, bouncy, active-high.
- sw_run  input  1  raw slide switch; 1 = free-run, 0 = single-step.
- O_DIV_RST  output  1  active-high reset to divider and CPU.
- O_CPU_EN  output  1  CPU clock enable.
- O_MODE  output  1  debounced sw_run.
- O_STEP_CNT  output  16  number of steps issued since the last reset event.

Behaviour:
Reset (rst_n=0 at a posedge):
- Synchronizers and debounced values cleared to 0; debounce, hold and pulse counters cleared.
- State = S_RESET.
- O_DIV_RST=1, O_CPU_EN=0, O_MODE=0, O_STEP_CNT=0.
- All outputs registered.

Input conditioning:
- Each raw input passes through a 2-flop synchronizer.
- Per-input debouncer counts consecutive cycles where synchronized value != debounced value; any cycle with equality clears the count.
- When count reaches DEBOUNCE_CYCLES, debounced value flips and count clears.
- Raw-to-debounced latency = 2 + DEBOUNCE_CYCLES cycles; glitches shorter than DEBOUNCE_CYCLES are never propagated.
- Rising edges of debounced btn_rst/btn_step are detected with a registered copy (one-cycle pulse, +1 cycle).

FSM states: S_RESET, S_RUN, S_IDLE, S_STEP.
- S_RESET:
  - O_DIV_RST=1, O_CPU_EN=0, hold counter increments.
  - Exit when hold count >= RST_HOLD_CYCLES and debounced btn_rst=0: to S_RUN if debounced sw_run=1, else S_IDLE.
  - Holding the button extends reset indefinitely.
- S_RUN: O_DIV_RST=0, O_CPU_EN=1; debounced sw_run=0 -> S_IDLE next cycle; step edges ignored.
- S_IDLE:
  - O_DIV_RST=0, O_CPU_EN=0.
  - Step rising edge -> S_STEP, pulse counter loaded, O_STEP_CNT+1.
  - sw_run=1 -> S_RUN.
- S_STEP:
  - O_CPU_EN=1 for exactly STEP_PULSE_CYCLES cycles, then S_RUN if sw_run=1, else S_IDLE.
  - Further step edges during S_STEP are dropped, not queued.
  - A mode change during S_STEP takes effect only after the pulse completes.

Global rules:
- A debounced btn_rst rising edge in any state -> S_RESET next cycle: hold counter cleared, O_STEP_CNT cleared, O_CPU_EN=0 immediately.
- Reset edge and step edge in the same cycle: reset wins, step is discarded.
- O_STEP_CNT wraps 0xFFFF -> 0x0000.
- Outputs change only on I_CLK posedge.
- Synchronous reset mid-step aborts the pulse the same edge.

Test Plan (sim params DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3, STEP_PULSE_CYCLES=10):
1. rst_n low 2 cycles then high, sw_run=1 held -> O_DIV_RST=1 for at least 3 cycles after release, then 0 with O_CPU_EN=1 continuously; O_STEP_CNT=0.
2. sw_run=0, btn_step pulsed high 20 cycles -> O_CPU_EN high exactly 10 consecutive cycles, starting 2+4+1 cycles after the raw rise plus one FSM cycle; O_STEP_CNT=1; a second press gives 2.
3. btn_step toggling every 2 cycles for 30 cycles, then low -> no O_CPU_EN pulse, O_STEP_CNT unchanged.
4. Second step press landing during an active 10-cycle pulse -> pulse length stays 10, O_STEP_CNT increments once only.
5. btn_rst held 50 cycles while in S_RUN -> O_CPU_EN=0 and O_DIV_RST=1 for the whole hold; O_STEP_CNT=0; run resumes at least 3 cycles after debounced release.
6. Preload 0xFFFF steps (force or loop), one more press -> O_STEP_CNT=0x0000; rst_n asserted mid-pulse -> O_CPU_EN=0 and O_DIV_RST=1 on the next edge.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: board-side run/step controller feeding the clock divider.
// Conditions the reset button, step button and run switch, then drives the
// divider reset and a CPU clock enable (free-run or one period per step).

// Per-input conditioner: 2-flop synchronizer followed by a stability debouncer.
module cpu_run_ctrl_db #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic I_CLK,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // sync[1] is the metastability-safe copy; db flips only after a full run of disagreement
  always_ff @(posedge I_CLK) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] != db) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          db  <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int RST_HOLD_CYCLES   = 16,
  parameter int STEP_PULSE_CYCLES = 10
) (
  input  logic        I_CLK,
  input  logic        rst_n,
  input  logic        btn_rst,
  input  logic        btn_step,
  input  logic        sw_run,
  output logic        O_DIV_RST,
  output logic        O_CPU_EN,
  output logic        O_MODE,
  output logic [15:0] O_STEP_CNT
);
  // Conditioned input lanes: 0 = reset button, 1 = step button, 2 = run switch
  localparam int NUM_IN = 3;
  localparam int HW     = $clog2(RST_HOLD_CYCLES + 1);
  localparam int PW     = $clog2(STEP_PULSE_CYCLES + 1);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_IDLE, S_STEP} state_t;

  logic [NUM_IN-1:0] raw, db;
  logic [1:0]        db_q, rise;

  state_t        state, state_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [PW-1:0] pulse, pulse_nxt;
  logic [15:0]   step_cnt, step_cnt_nxt;

  assign raw = {sw_run, btn_step, btn_rst};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    cpu_run_ctrl_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .I_CLK (I_CLK),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .db    (db[i])
    );
  end

  // Registered one-cycle rising-edge pulses for the two buttons
  always_ff @(posedge I_CLK) begin
    if (!rst_n) begin
      db_q <= '0;
      rise <= '0;
    end else begin
      db_q <= db[1:0];
      rise <= db[1:0] & ~db_q;
    end
  end

  // Next-state logic; a reset-button edge overrides everything, including a same-cycle step
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold;
    pulse_nxt    = pulse;
    step_cnt_nxt = step_cnt;
    if (rise[0]) begin
      state_nxt    = S_RESET;
      hold_nxt     = '0;
      step_cnt_nxt = '0;
    end else begin
      case (state)
        S_RESET: begin
          if (hold >= HW'(RST_HOLD_CYCLES) && !db[0])
            state_nxt = db[2] ? S_RUN : S_IDLE;
          else if (hold < HW'(RST_HOLD_CYCLES))
            hold_nxt = hold + HW'(1);
        end
        S_RUN: begin
          if (!db[2]) state_nxt = S_IDLE;
        end
        S_IDLE: begin
          if (rise[1]) begin
            state_nxt    = S_STEP;
            pulse_nxt    = PW'(STEP_PULSE_CYCLES - 1);
            step_cnt_nxt = step_cnt + 16'd1;
          end else if (db[2]) begin
            state_nxt = S_RUN;
          end
        end
        S_STEP: begin
          // step edges seen here are dropped; mode is only looked at once the pulse ends
          if (pulse == '0) state_nxt = db[2] ? S_RUN : S_IDLE;
          else             pulse_nxt = pulse - PW'(1);
        end
        default: state_nxt = S_RESET;
      endcase
    end
  end

  // State register; outputs are decoded from the next state so they are plain flops
  always_ff @(posedge I_CLK) begin
    if (!rst_n) begin
      state     <= S_RESET;
      hold      <= '0;
      pulse     <= '0;
      step_cnt  <= '0;
      O_DIV_RST <= 1'b1;
      O_CPU_EN  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      pulse     <= pulse_nxt;
      step_cnt  <= step_cnt_nxt;
      O_DIV_RST <= (state_nxt == S_RESET);
      O_CPU_EN  <= (state_nxt == S_RUN) || (state_nxt == S_STEP);
    end
  end

  assign O_MODE     = db[2];
  assign O_STEP_CNT = step_cnt;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random input wiggling, checked
// every cycle against a delay-line/event reference model through a scoreboard queue.
module tb_cpu_run_ctrl;
  localparam int D = 4;
  localparam int H = 3;
  localparam int P = 10;

  logic        I_CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_rst = 1'b0, btn_step = 1'b0, sw_run = 1'b0;
  logic        O_DIV_RST, O_CPU_EN, O_MODE;
  logic [15:0] O_STEP_CNT;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(D), .RST_HOLD_CYCLES(H), .STEP_PULSE_CYCLES(P)
  ) dut (
    .I_CLK      (I_CLK),
    .rst_n      (rst_n),
    .btn_rst    (btn_rst),
    .btn_step   (btn_step),
    .sw_run     (sw_run),
    .O_DIV_RST  (O_DIV_RST),
    .O_CPU_EN   (O_CPU_EN),
    .O_MODE     (O_MODE),
    .O_STEP_CNT (O_STEP_CNT)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct packed {
    logic        div;
    logic        en;
    logic        mode;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   preload_seq = 0;

  // ---------------- reference model ----------------
  typedef enum {PH_HOLD, PH_FREE, PH_PARK, PH_PULSE} ph_t;
  ph_t ph = PH_HOLD;
  int  r1[3], r2[3];          // raw samples 1 and 2 edges ago
  int  d0[3], d1[3], d2[3];   // debounced level now, 1 and 2 edges ago
  int  mis[3];                // length of current disagreement run
  int  held = 0, left = 0, mcnt = 0, preload_seen = 0;

  task automatic model_edge();
    logic [2:0] rv;
    bit rr, sr, br, sw;
    int lag, nd;
    exp_t e;
    rv = {sw_run, btn_step, btn_rst};
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r1[i] = 0; r2[i] = 0; d0[i] = 0; d1[i] = 0; d2[i] = 0; mis[i] = 0;
      end
      ph = PH_HOLD; held = 0; left = 0; mcnt = 0;
      preload_seen = preload_seq;
    end else begin
      rr = (d1[0] != 0) && (d2[0] == 0);
      sr = (d1[1] != 0) && (d2[1] == 0);
      br = (d0[0] != 0);
      sw = (d0[2] != 0);
      for (int i = 0; i < 3; i++) begin
        lag = r2[i];
        r2[i] = r1[i];
        r1[i] = int'(rv[i]);
        nd = d0[i];
        if (lag != d0[i]) begin
          mis[i]++;
          if (mis[i] == D) begin nd = lag; mis[i] = 0; end
        end else mis[i] = 0;
        d2[i] = d1[i]; d1[i] = d0[i]; d0[i] = nd;
      end
      if (preload_seq != preload_seen) begin
        preload_seen = preload_seq;
        mcnt = 16'hFFFF;
      end
      if (rr) begin
        ph = PH_HOLD; held = 0; mcnt = 0;
      end else begin
        case (ph)
          PH_HOLD:  if (held >= H && !br) ph = sw ? PH_FREE : PH_PARK; else held++;
          PH_FREE:  if (!sw) ph = PH_PARK;
          PH_PARK:  if (sr) begin ph = PH_PULSE; left = P; mcnt = (mcnt + 1) & 16'hFFFF; end
                    else if (sw) ph = PH_FREE;
          PH_PULSE: begin left--; if (left == 0) ph = sw ? PH_FREE : PH_PARK; end
          default:  ph = PH_HOLD;
        endcase
      end
    end
    e.div  = (ph == PH_HOLD);
    e.en   = (ph == PH_FREE) || (ph == PH_PULSE);
    e.mode = (d0[2] != 0);
    e.cnt  = mcnt[15:0];
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge I_CLK);
    model_edge();
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge I_CLK);
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("div_rst",  int'(O_DIV_RST),  int'(e.div));
      chk("cpu_en",   int'(O_CPU_EN),   int'(e.en));
      chk("mode",     int'(O_MODE),     int'(e.mode));
      chk("step_cnt", int'(O_STEP_CNT), int'(e.cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge I_CLK);
  endtask

  task automatic press(input int hi, input int lo);
    btn_step = 1'b1; cyc(hi);
    btn_step = 1'b0; cyc(lo);
  endtask

  initial begin
    // 1: reset with run switch on
    rst_n = 1'b0; sw_run = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(30);
    // 2: single-step mode, two clean presses
    sw_run = 1'b0; cyc(20);
    press(20, 30);
    press(20, 30);
    // 3: bounce shorter than the debounce window
    for (int k = 0; k < 15; k++) begin
      btn_step = ~btn_step; cyc(2);
    end
    btn_step = 1'b0; cyc(20);
    // 4: second press lands inside an active pulse
    press(4, 4);
    press(10, 30);
    // 5: reset button held while free-running
    sw_run = 1'b1; cyc(30);
    btn_rst = 1'b1; cyc(50);
    btn_rst = 1'b0; cyc(40);
    // 6: counter wrap, then synchronous reset mid-pulse
    sw_run = 1'b0; cyc(20);
    #2 force dut.step_cnt = 16'hFFFF;
    preload_seq++;
    cyc(1);
    #2 release dut.step_cnt;
    cyc(2);
    press(10, 30);
    btn_step = 1'b1; cyc(12);
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; btn_step = 1'b0; cyc(40);
    // random wiggling of every input
    for (int k = 0; k < 250; k++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 3) begin
        rst_n = 1'b0; cyc($urandom_range(1, 3)); rst_n = 1'b1;
      end else if (sel < 10) btn_rst = ~btn_rst;
      else if (sel < 22) sw_run = ~sw_run;
      else btn_step = ~btn_step;
      cyc($urandom_range(1, 12));
    end
    btn_rst = 1'b0; btn_step = 1'b0; cyc(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
